// File: rtl/ctrl_microondas_pkg.sv
// Shared encodings and lookup tables for the second-generation microwave controller.
package ctrl_microondas_pkg;

    typedef enum logic [1:0] {
        StProg  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StAlarm = 2'b11
    } state_e;

    localparam logic [1:0] PresetNone    = 2'd0;
    localparam logic [1:0] PresetPopcorn = 2'd1;
    localparam logic [1:0] PresetLasagna = 2'd2;
    localparam logic [1:0] PresetSteak   = 2'd3;

    function automatic int unsigned step_secs(input logic [1:0] sel);
        int unsigned s;
        case (sel)
            2'b00:   s = 1;
            2'b01:   s = 10;
            2'b10:   s = 60;
            default: s = 600;
        endcase
        return s;
    endfunction

    // Raw cook times in seconds; the caller clamps them to its own time ceiling.
    function automatic int unsigned preset_secs(input logic [1:0] p);
        int unsigned s;
        case (p)
            PresetPopcorn: s = 172;
            PresetLasagna: s = 742;
            PresetSteak:   s = 96;
            default:       s = 0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/edge_detector.sv
// Rising-edge detector: input is registered, then compared with its previous sample.
module edge_detector (
    input  logic clock,
    input  logic reset,
    input  logic sig,
    output logic rise
);

    logic sig_q;
    logic sig_qq;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sig_q  <= 1'b0;
            sig_qq <= 1'b0;
        end else begin
            sig_q  <= sig;
            sig_qq <= sig_q;
        end
    end

    assign rise = sig_q & ~sig_qq;

endmodule

// File: rtl/microondas_tick_gen.sv
// Seconds prescaler with enable/clear and the heater PWM phase counter advanced per tick.
module microondas_tick_gen #(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned NUM_LEVELS = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          clr,
    output logic                          tick,
    output logic [$clog2(NUM_LEVELS)-1:0] phase_next
);

    localparam int unsigned CW = $clog2(TICK_DIV);
    localparam int unsigned LW = $clog2(NUM_LEVELS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] phase_q;

    assign tick = en && (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d      = cnt_q;
        phase_next = phase_q;
        if (clr) begin
            cnt_d      = '0;
            phase_next = '0;
        end else if (en) begin
            if (tick) begin
                cnt_d      = '0;
                phase_next = (phase_q == LW'(NUM_LEVELS - 1)) ? '0 : phase_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_next;
        end
    end

endmodule

// File: rtl/ctrl_microondas_gen2.sv
// Self-contained microwave controller: programming, countdown, heater PWM and end alarm.
// Define CTRL_MICROONDAS_QUICK_START_EN for 30 s quick start and +30 s in RUN.
module ctrl_microondas_gen2
    import ctrl_microondas_pkg::*;
#(
    parameter int unsigned TICK_DIV   = 100000000,
    parameter int unsigned MAX_MIN    = 99,
    parameter int unsigned NUM_LEVELS = 3,
    parameter int unsigned ALARM_SECS = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          pause,
    input  logic                          plus,
    input  logic                          minus,
    input  logic                          door,
    input  logic                          pot_sel,
    input  logic [1:0]                    step_sel,
    input  logic [1:0]                    preset,
    output logic [6:0]                    min_out,
    output logic [5:0]                    sec_out,
    output logic [$clog2(NUM_LEVELS)-1:0] level,
    output logic [1:0]                    state_out,
    output logic                          heater_on,
    output logic                          lamp_on,
    output logic                          done,
    output logic                          alarm
);

    localparam int unsigned TMAX = MAX_MIN * 60 + 59;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned LW   = $clog2(NUM_LEVELS);
    localparam int unsigned AW   = $clog2(ALARM_SECS + 1);
    localparam logic [LW-1:0] LvlTop = LW'(NUM_LEVELS - 1);
    localparam logic [LW-1:0] LvlMid = LW'(NUM_LEVELS / 2);
`ifdef CTRL_MICROONDAS_QUICK_START_EN
    localparam int unsigned QuickSecs = 30;
`endif

    function automatic logic [TW-1:0] t_add(input logic [TW-1:0] t, input int unsigned d);
        int unsigned s;
        s = 32'(t) + d;
        return (s > TMAX) ? TW'(TMAX) : TW'(s);
    endfunction

    function automatic logic [TW-1:0] t_sub(input logic [TW-1:0] t, input int unsigned d);
        return (32'(t) > d) ? TW'(32'(t) - d) : '0;
    endfunction

    function automatic logic [LW-1:0] preset_level(input logic [1:0] p);
        logic [LW-1:0] l;
        case (p)
            PresetPopcorn: l = LvlTop;
            PresetLasagna: l = LvlMid;
            default:       l = '0;
        endcase
        return l;
    endfunction

    // Bit order: start, stop, pause, plus, minus, door.
    logic [5:0] btn_raw, btn_e;
    logic       start_e, stop_e, pause_e, plus_e, minus_e, door_e;

    assign btn_raw = {door, minus, plus, pause, stop, start};

    for (genvar i = 0; i < 6; i++) begin : g_edge
        edge_detector u_edge (
            .clock (clock),
            .reset (reset),
            .sig   (btn_raw[i]),
            .rise  (btn_e[i])
        );
    end

    assign {door_e, minus_e, plus_e, pause_e, stop_e, start_e} = btn_e;

    state_e        state_q, state_d;
    logic [TW-1:0] t_q, t_d;
    logic [LW-1:0] level_q, level_d;
    logic [AW-1:0] alarm_cnt_q, alarm_cnt_d;
    logic          heater_q, done_q, done_d;
    logic          tick, tick_en, tick_clr;
    logic [LW-1:0] phase_next;

    assign tick_en = (state_q == StRun) || (state_q == StAlarm);

    microondas_tick_gen #(
        .TICK_DIV   (TICK_DIV),
        .NUM_LEVELS (NUM_LEVELS)
    ) u_tick_gen (
        .clock      (clock),
        .reset      (reset),
        .en         (tick_en),
        .clr        (tick_clr),
        .tick       (tick),
        .phase_next (phase_next)
    );

    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        level_d     = level_q;
        alarm_cnt_d = '0;
        done_d      = 1'b0;
        tick_clr    = 1'b0;
        unique case (state_q)
            StProg: begin
                if (stop_e) begin
                    t_d = '0;
                end else begin
                    if (preset != PresetNone) begin
                        t_d     = t_add('0, preset_secs(preset));
                        level_d = preset_level(preset);
                    end else if (plus_e || minus_e) begin
                        if (!pot_sel) begin
                            t_d = plus_e ? t_add(t_q, step_secs(step_sel))
                                         : t_sub(t_q, step_secs(step_sel));
                        end else if (plus_e) begin
                            level_d = (level_q == LvlTop) ? level_q : level_q + 1'b1;
                        end else begin
                            level_d = (level_q == '0) ? level_q : level_q - 1'b1;
                        end
                    end
                    // The T > 0 test uses the time held before this cycle's adjustment.
                    if (start_e && !door) begin
                        if (t_q != '0) begin
                            state_d  = StRun;
                            tick_clr = 1'b1;
                        end
`ifdef CTRL_MICROONDAS_QUICK_START_EN
                        else if (preset == PresetNone) begin
                            t_d      = TW'(QuickSecs);
                            level_d  = LvlTop;
                            state_d  = StRun;
                            tick_clr = 1'b1;
                        end
`endif
                    end
                end
            end
            StRun: begin
                if (stop_e) begin
                    state_d = StProg;
                    t_d     = '0;
                end else if (door || pause_e) begin
                    state_d = StPause;
                end else begin
`ifdef CTRL_MICROONDAS_QUICK_START_EN
                    if (plus_e) t_d = t_add(t_q, QuickSecs);
`endif
                    if (tick) begin
                        if (t_d == TW'(1)) begin
                            state_d = StAlarm;
                            done_d  = 1'b1;
                        end
                        t_d = t_d - 1'b1;
                    end
                end
            end
            StPause: begin
                if (stop_e) begin
                    state_d = StProg;
                    t_d     = '0;
                end else if ((start_e || pause_e) && !door) begin
                    state_d = StRun;
                end
            end
            StAlarm: begin
                alarm_cnt_d = alarm_cnt_q;
                if (stop_e || start_e || door_e) begin
                    state_d = StProg;
                end else if (tick) begin
                    if (alarm_cnt_q == AW'(ALARM_SECS - 1)) state_d = StProg;
                    else alarm_cnt_d = alarm_cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= StProg;
            t_q         <= '0;
            level_q     <= '0;
            alarm_cnt_q <= '0;
            heater_q    <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            level_q     <= level_d;
            alarm_cnt_q <= alarm_cnt_d;
            heater_q    <= (state_d == StRun) && !door && (phase_next <= level_d);
            done_q      <= done_d;
        end
    end

    assign min_out   = 7'(t_q / TW'(60));
    assign sec_out   = 6'(t_q % TW'(60));
    assign level     = level_q;
    assign state_out = state_q;
    assign heater_on = heater_q;
    assign lamp_on   = door || (state_q == StRun);
    assign done      = done_q;
    assign alarm     = (state_q == StAlarm);

endmodule

// File: tb/tb_ctrl_microondas_gen2.sv
// Directed bench for ctrl_microondas_gen2 with a per-cycle behavioural model and literal checks.
module tb_ctrl_microondas_gen2;

    localparam int TD   = 4;
    localparam int NL   = 3;
    localparam int MM   = 99;
    localparam int AS   = 5;
    localparam int TMAX = MM * 60 + 59;

    logic       clock, reset, door, pot_sel;
    logic [4:0] btn;  // start, stop, pause, plus, minus
    logic [1:0] step_sel, preset;
    logic [6:0] min_out;
    logic [5:0] sec_out;
    logic [1:0] level, state_out;
    logic       heater_on, lamp_on, done, alarm;

    ctrl_microondas_gen2 #(
        .TICK_DIV   (TD),
        .MAX_MIN    (MM),
        .NUM_LEVELS (NL),
        .ALARM_SECS (AS)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (btn[0]),
        .stop      (btn[1]),
        .pause     (btn[2]),
        .plus      (btn[3]),
        .minus     (btn[4]),
        .door      (door),
        .pot_sel   (pot_sel),
        .step_sel  (step_sel),
        .preset    (preset),
        .min_out   (min_out),
        .sec_out   (sec_out),
        .level     (level),
        .state_out (state_out),
        .heater_on (heater_on),
        .lamp_on   (lamp_on),
        .done      (done),
        .alarm     (alarm)
    );

    int total = 0;
    int bad = 0;
    int done_pulses = 0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model state: 0 PROG, 1 RUN, 2 PAUSE, 3 ALARM; time in plain seconds.
    int  m_state, m_t, m_lvl, m_pre, m_phase, m_acnt;
    bit  m_heat, m_done;
    bit [5:0] h1, h2;
    int steps[4]    = '{1, 10, 60, 600};
    int preset_t[4] = '{0, 172, 742, 96};
    int preset_l[4] = '{0, NL - 1, NL / 2, 0};

    function automatic int min_i(input int a, input int b);
        return (a < b) ? a : b;
    endfunction
    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic model_reset();
        m_state = 0; m_t = 0; m_lvl = 0; m_pre = 0; m_phase = 0; m_acnt = 0;
        m_heat = 0; m_done = 0; h1 = '0; h2 = '0;
    endtask

    task automatic model_step();
        bit [5:0] e;
        bit st, sp, pa, pl, mi, de, en, tk;
        int old_t;
        e = h1 & ~h2;
        h2 = h1;
        h1 = {door, btn};
        {de, mi, pl, pa, sp, st} = e;
        en = (m_state == 1) || (m_state == 3);
        tk = en && (m_pre == TD - 1);
        if (en) begin
            if (tk) begin
                m_pre = 0;
                m_phase = (m_phase + 1) % NL;
            end else begin
                m_pre = m_pre + 1;
            end
        end
        m_done = 0;
        old_t = m_t;
        case (m_state)
            0: begin
                if (sp) m_t = 0;
                else begin
                    if (preset != 0) begin
                        m_t = min_i(preset_t[preset], TMAX);
                        m_lvl = preset_l[preset];
                    end else if (pl || mi) begin
                        if (!pot_sel) m_t = pl ? min_i(m_t + steps[step_sel], TMAX)
                                               : max_i(m_t - steps[step_sel], 0);
                        else m_lvl = pl ? min_i(m_lvl + 1, NL - 1) : max_i(m_lvl - 1, 0);
                    end
                    if (st && !door) begin
                        if (old_t > 0) begin
                            m_state = 1; m_pre = 0; m_phase = 0;
                        end
`ifdef CTRL_MICROONDAS_QUICK_START_EN
                        else if (preset == 0) begin
                            m_t = 30; m_lvl = NL - 1; m_state = 1; m_pre = 0; m_phase = 0;
                        end
`endif
                    end
                end
            end
            1: begin
                if (sp) begin
                    m_state = 0; m_t = 0;
                end else if (door || pa) begin
                    m_state = 2;
                end else begin
`ifdef CTRL_MICROONDAS_QUICK_START_EN
                    if (pl) m_t = min_i(m_t + 30, TMAX);
`endif
                    if (tk) begin
                        m_t = m_t - 1;
                        if (m_t == 0) begin
                            m_state = 3; m_acnt = 0; m_done = 1;
                        end
                    end
                end
            end
            2: begin
                if (sp) begin
                    m_state = 0; m_t = 0;
                end else if ((st || pa) && !door) begin
                    m_state = 1;
                end
            end
            default: begin
                if (sp || st || de) m_state = 0;
                else if (tk) begin
                    m_acnt = m_acnt + 1;
                    if (m_acnt == AS) m_state = 0;
                end
            end
        endcase
        m_heat = (m_state == 1) && !door && (m_phase <= m_lvl);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or posedge reset);
            if (reset) model_reset();
            else model_step();
        end
    end

    initial forever begin
        @(negedge clock);
        if (!reset) begin
            check("min_out", int'(min_out), m_t / 60);
            check("sec_out", int'(sec_out), m_t % 60);
            check("level", int'(level), m_lvl);
            check("state_out", int'(state_out), m_state);
            check("heater_on", int'(heater_on), int'(m_heat));
            check("lamp_on", int'(lamp_on), int'(door || (m_state == 1)));
            check("done", int'(done), int'(m_done));
            check("alarm", int'(alarm), int'(m_state == 3));
            if (done) done_pulses++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic press(input int idx);
        @(posedge clock); #1 btn[idx] = 1'b1;
        @(posedge clock); #1 btn[idx] = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic set_time(input logic [1:0] s, input int n);
        press(1);
        step_sel = s;
        for (int i = 0; i < n; i++) press(3);
        settle();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_state"}, int'(state_out), 0);
        check({tag, "_min"}, int'(min_out), 0);
        check({tag, "_sec"}, int'(sec_out), 0);
        check({tag, "_level"}, int'(level), 0);
        check({tag, "_heater"}, int'(heater_on), 0);
        check({tag, "_lamp"}, int'(lamp_on), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_alarm"}, int'(alarm), 0);
    endtask

    initial begin
        bit found;
        int cnt;
        reset = 1'b1; btn = '0; door = 1'b0; pot_sel = 1'b0; step_sel = 2'b00; preset = 2'd0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock); #1;
        check_outputs_zero("reset");

        // Step entry and saturation.
        step_sel = 2'b10;
        for (int i = 0; i < 3; i++) press(3);
        settle();
        check("plus3_min", int'(min_out), 3);
        check("plus3_sec", int'(sec_out), 0);
        step_sel = 2'b00;
        for (int i = 0; i < 200; i++) press(4);
        settle();
        check("minus_floor_min", int'(min_out), 0);
        check("minus_floor_sec", int'(sec_out), 0);
        step_sel = 2'b11;
        for (int i = 0; i < 11; i++) press(3);
        settle();
        check("ceil_min", int'(min_out), 99);
        check("ceil_sec", int'(sec_out), 59);
        press(1);
        settle();
        check("stop_prog_sec", int'(sec_out), 0);

        // Lasagna preset, 8 ticks, heater duty at middle level.
        preset = 2'd2;
        settle();
        check("preset_min", int'(min_out), 12);
        check("preset_sec", int'(sec_out), 22);
        check("preset_level", int'(level), 1);
        press(0);
        repeat (34) @(posedge clock);
        #1;
        check("run8_min", int'(min_out), 12);
        check("run8_sec", int'(sec_out), 14);
        check("run8_state", int'(state_out), 1);
        check("run8_heater", int'(heater_on), 0);
        check("run8_lamp", int'(lamp_on), 1);
        repeat (4) @(posedge clock);
        #1;
        check("run9_sec", int'(sec_out), 13);
        check("run9_heater", int'(heater_on), 1);
        preset = 2'd0;
        press(1);
        settle();
        check("stop_run_state", int'(state_out), 0);

        // Door pause/resume and completion alarm.
        set_time(2'b00, 3);
        press(0);
        repeat (5) @(posedge clock);
        #1 door = 1'b1;
        @(posedge clock); #1;
        check("door_state", int'(state_out), 2);
        check("door_sec", int'(sec_out), 2);
        check("door_heater", int'(heater_on), 0);
        check("door_lamp", int'(lamp_on), 1);
        press(0);
        settle();
        check("door_start_ignored", int'(state_out), 2);
        door = 1'b0;
        @(posedge clock); #1;
        press(2);
        settle();
        check("resume_state", int'(state_out), 1);
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            if (done) found = 1'b1;
        end
        check("done_seen", int'(found), 1);
        check("done_state", int'(state_out), 3);
        check("done_alarm", int'(alarm), 1);
        cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clock);
            cnt++;
            if (state_out == 2'b00) found = 1'b1;
        end
        check("alarm_cycles", cnt, AS * TD);

        // Stop coinciding with a tick at 1:00.
        set_time(2'b10, 1);
        press(0);
        repeat (3) @(posedge clock);
        #1 btn[1] = 1'b1;
        @(posedge clock); #1 btn[1] = 1'b0;
        settle();
        check("stop_tick_state", int'(state_out), 0);
        check("stop_tick_min", int'(min_out), 0);
        check("stop_tick_sec", int'(sec_out), 0);

        // Start with T = 0.
        press(0);
`ifdef CTRL_MICROONDAS_QUICK_START_EN
        @(posedge clock); #1;
        check("qs_state", int'(state_out), 1);
        check("qs_sec", int'(sec_out), 30);
        check("qs_level", int'(level), NL - 1);
        press(3);
        @(posedge clock); #1;
        check("qs_plus_min", int'(min_out), 1);
        check("qs_plus_sec", int'(sec_out), 0);
        press(1);
        settle();
`else
        settle();
        check("zero_start_state", int'(state_out), 0);
        check("zero_start_sec", int'(sec_out), 0);
`endif

        // Power level saturation, then reset mid-run at 5:00.
        pot_sel = 1'b1;
        for (int i = 0; i < 3; i++) press(4);
        settle();
        check("level_floor", int'(level), 0);
        for (int i = 0; i < 3; i++) press(3);
        settle();
        check("level_ceil", int'(level), NL - 1);
        pot_sel = 1'b0;
        set_time(2'b10, 5);
        check("five_min", int'(min_out), 5);
        press(0);
        repeat (6) @(posedge clock);
        #2 reset = 1'b1;
        #1;
        check_outputs_zero("async_reset");
        @(posedge clock); #1 reset = 1'b0;
        settle();
        check("done_pulse_count", done_pulses, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
